// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC,
// PC step and fetch-window helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC     = 32'h0040_0000;
    localparam int          DEFAULT_MEMORY_DEPTH = 64;
    localparam int          PC_STEP              = 4;

    // Byte offset from the window base to the last fetchable word.
    function automatic int window_span(input int depth);
        return PC_STEP * (depth - 1);
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter holding register: reset value, load, increment by one word, hold.
module pc_register
    import fetch_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] pc
);

    // Load wins over increment; the top never asserts both together.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_VALUE;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + WIDTH'(PC_STEP);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses Program_Memory and registers each returned
// instruction into a valid/ready IF/ID slot with redirect, stall and sticky fault.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = DEFAULT_MEMORY_DEPTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  ready_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] Address_o,
    output logic [DATA_WIDTH-1:0] instruction_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic                  valid_o,
    output logic                  fault_o,
    output logic [15:0]           fetch_count_o,
    output fetch_state_t          state_o
);

    // Handshake: the output slot transfers on any cycle where valid_o && ready_i.
    // While valid_o is high and ready_i low, instruction_o/pc_o stay frozen.
    localparam logic [DATA_WIDTH-1:0] LAST_PC = RESET_PC + DATA_WIDTH'(window_span(MEMORY_DEPTH));

    fetch_state_t          state_q;
    fetch_state_t          state_d;
    logic [DATA_WIDTH-1:0] pc;
    logic                  transfer;
    logic                  slot_free;
    logic                  pc_ok;
    logic                  misaligned;
    logic                  fire;
    logic                  pc_load;
    logic                  set_fault;
    logic                  clear_valid;

    pc_register #(
        .WIDTH       (DATA_WIDTH),
        .RESET_VALUE (RESET_PC)
    ) u_pc_register (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .inc        (fire),
        .load_value (redirect_pc_i),
        .pc         (pc)
    );

    assign transfer   = valid_o && ready_i;
    assign slot_free  = !valid_o || ready_i;
    assign pc_ok      = (pc >= RESET_PC) && (pc <= LAST_PC);
    assign misaligned = redirect_pc_i[1:0] != 2'b00;

    assign Address_o  = pc;
    assign pc_plus4_o = pc_o + DATA_WIDTH'(PC_STEP);
    assign state_o    = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect outranks fire; a bad target faults without touching the PC.
    always_comb begin
        state_d     = state_q;
        fire        = 1'b0;
        pc_load     = 1'b0;
        set_fault   = 1'b0;
        clear_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect_i && misaligned) begin
                    set_fault = 1'b1;
                    state_d   = ST_FAULT;
                end else begin
                    pc_load = redirect_i;
                    if (start_i) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (redirect_i) begin
                    clear_valid = 1'b1;
                    if (misaligned) begin
                        set_fault = 1'b1;
                        state_d   = ST_FAULT;
                    end else begin
                        pc_load = 1'b1;
                    end
                end else if (slot_free) begin
                    if (pc_ok) begin
                        fire = 1'b1;
                    end else begin
                        set_fault   = 1'b1;
                        clear_valid = 1'b1;
                        state_d     = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                clear_valid = transfer;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instruction_o <= '0;
            pc_o          <= '0;
            valid_o       <= 1'b0;
            fault_o       <= 1'b0;
            fetch_count_o <= '0;
        end else begin
            if (fire) begin
                instruction_o <= Instruction_i;
                pc_o          <= pc;
                valid_o       <= 1'b1;
            end else if (clear_valid) begin
                valid_o <= 1'b0;
            end
            if (set_fault) begin
                fault_o <= 1'b1;
            end
            if (transfer && (fetch_count_o != 16'hFFFF)) begin
                fetch_count_o <= fetch_count_o + 16'd1;
            end
        end
    end

endmodule
